// File: rtl/seg_int.sv
// seg_int: reads a 4-digit 7-segment display word back into a binary number.
//
// Each byte of the display word is decoded to a BCD digit. The BCD value is then
// converted to binary with reverse double-dabble, one bit per cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   digits     segment word, [7:0] = ones digit .. [31:24] = thousands; bit 7 of each byte is DP
//   convert    start request, only sampled while idle
//   num        binary result, held until the next completion or reset
//   conv_done  one-cycle completion pulse (success or error)
//   error      last conversion saw an invalid segment pattern; sticky until next accepted start
//   busy       high whenever a conversion is in flight
module seg_int #(
    parameter int unsigned N_BITS = 14,
    parameter int unsigned N_DIG  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_DIG-1:0]   digits,
    input  logic                 convert,
    output logic [N_BITS-1:0]    num,
    output logic                 conv_done,
    output logic                 error,
    output logic                 busy
);

    localparam int unsigned BcdW = 4 * N_DIG;
    localparam int unsigned SrW  = BcdW + N_BITS;
    localparam int unsigned CntW = $clog2(N_BITS);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StConv = 3'd2,
        StDone = 3'd3,
        StErr  = 3'd4
    } state_e;

    // Returns {valid, bcd}. A blank digit reads as zero.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F, 7'h00: res = 5'h10;
            7'h06:        res = 5'h11;
            7'h5B:        res = 5'h12;
            7'h4F:        res = 5'h13;
            7'h66:        res = 5'h14;
            7'h6D:        res = 5'h15;
            7'h7D:        res = 5'h16;
            7'h07:        res = 5'h17;
            7'h7F:        res = 5'h18;
            7'h6F:        res = 5'h19;
            default:      res = 5'h00;
        endcase
        return res;
    endfunction

    state_e                        state_q, state_d;
    logic [N_DIG-1:0][6:0]         seg_q, seg_d;
    logic [SrW-1:0]                sr_q, sr_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [N_BITS-1:0]             num_q, num_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;

    logic [4:0]                    dec;
    logic                          dec_ok;
    logic [BcdW-1:0]               bcd_all;
    logic [SrW-1:0]                sr_shift;

    // Decimal-point bits carry no value information.
    logic [N_DIG-1:0]              dp_unused;
    always_comb begin
        dp_unused = '0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            dp_unused[i] = digits[8*i+7];
        end
    end

    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        done_d   = 1'b0;
        error_d  = error_q;
        dec      = '0;
        dec_ok   = 1'b1;
        bcd_all  = '0;
        sr_shift = '0;

        case (state_q)
            StIdle: begin
                if (convert) begin
                    for (int i = 0; i < int'(N_DIG); i++) begin
                        seg_d[i] = digits[8*i +: 7];
                    end
                    error_d = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                for (int i = 0; i < int'(N_DIG); i++) begin
                    dec              = seg_decode(seg_q[i]);
                    dec_ok           = dec_ok & dec[4];
                    bcd_all[4*i +: 4] = dec[3:0];
                end
                if (!dec_ok) begin
                    state_d = StErr;
                end else begin
                    sr_d    = {bcd_all, {N_BITS{1'b0}}};
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                // Shift right, then undo the "+3" of forward double-dabble on each BCD nibble.
                // Nibbles are corrected independently; no borrow crosses a nibble boundary.
                sr_shift = sr_q >> 1;
                for (int i = 0; i < int'(N_DIG); i++) begin
                    if (sr_shift[N_BITS+4*i +: 4] >= 4'd8) begin
                        sr_shift[N_BITS+4*i +: 4] = sr_shift[N_BITS+4*i +: 4] - 4'd3;
                    end
                end
                sr_d  = sr_shift;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N_BITS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                num_d   = sr_q[N_BITS-1:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                num_d   = '0;
                error_d = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            seg_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign num       = num_q;
    assign conv_done = done_q;
    assign error     = error_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_seg_int.sv
module tb_seg_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic        convert;
    logic [13:0] num;
    logic        conv_done;
    logic        error;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [13:0] num;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seg_int dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .convert   (convert),
        .num       (num),
        .conv_done (conv_done),
        .error     (error),
        .busy      (busy)
    );

    // Drive one convert pulse; returns just after the sampling edge E0.
    // digits is scrambled after E0 since the DUT must have latched it.
    task automatic start_conv(input logic [31:0] w);
        @(negedge clk);
        digits  = w;
        convert = 1'b1;
        @(posedge clk);
        #1;
        convert = 1'b0;
        digits  = $urandom();
    endtask

    // Count edges after E0 until conv_done is seen (bounded).
    task automatic wait_done(output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (conv_done === 1'b1) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        convert = 1'b0;
        digits  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (num !== 14'd0) begin
            failures++;
            $display("FAIL reset_num got=%0d exp=0", num);
        end
        checks++;
        if (conv_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_conv_done got=%b exp=0", conv_done);
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL reset_error got=%b exp=0", error);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        int   lat;
        bit   seen;
        sb.push_back('{14'd1234, 1'b0, 16});
        start_conv(32'h065B4F66);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_rise got=%b exp=1", busy);
        end
        wait_done(lat, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || lat != e.lat) begin
            failures++;
            $display("FAIL basic_latency seen=%b got=%0d exp=%0d", seen, lat, e.lat);
        end
        checks++;
        if (num !== e.num) begin
            failures++;
            $display("FAIL basic_num got=%0d exp=%0d", num, e.num);
        end
        checks++;
        if (error !== e.err) begin
            failures++;
            $display("FAIL basic_error got=%b exp=%b", error, e.err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_fall got=%b exp=0", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (conv_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b exp=0", conv_done);
        end
        checks++;
        if (num !== 14'd1234) begin
            failures++;
            $display("FAIL basic_num_hold got=%0d exp=1234", num);
        end
    endtask

    task automatic test_values();
        logic [31:0] words [6];
        logic [13:0] nums  [6];
        exp_t        e;
        int          lat;
        bit          seen;
        words = '{32'h6F6F6F6F, 32'h3F3F3F3F, 32'h0000006D, 32'h80BF80ED,
                  32'h6D7D077F, 32'h4F00065B};
        nums  = '{14'd9999, 14'd0, 14'd5, 14'd5, 14'd5678, 14'd3012};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{nums[i], 1'b0, 16});
            start_conv(words[i]);
            wait_done(lat, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || lat != e.lat) begin
                failures++;
                $display("FAIL values[%0d]_latency seen=%b got=%0d exp=%0d", i, seen, lat, e.lat);
            end
            checks++;
            if (num !== e.num || error !== e.err) begin
                failures++;
                $display("FAIL values[%0d]_num got=%0d/%b exp=%0d/%b", i, num, error, e.num, e.err);
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] bad [2];
        exp_t        e;
        int          lat;
        bit          seen;
        bad = '{32'h741C507C, 32'h3F3F3F3E};
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{14'd0, 1'b1, 2});
            start_conv(bad[i]);
            wait_done(lat, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || lat != e.lat) begin
                failures++;
                $display("FAIL error[%0d]_latency seen=%b got=%0d exp=%0d", i, seen, lat, e.lat);
            end
            checks++;
            if (num !== e.num || error !== e.err) begin
                failures++;
                $display("FAIL error[%0d]_result got=%0d/%b exp=%0d/%b", i, num, error, e.num, e.err);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL error[%0d]_busy got=%b exp=0", i, busy);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || num !== 14'd0) begin
            failures++;
            $display("FAIL error_sticky got=%b/%0d exp=1/0", error, num);
        end
        sb.push_back('{14'd42, 1'b0, 16});
        start_conv(32'h3F3F665B);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL error_clear_on_start got=%b exp=0", error);
        end
        wait_done(lat, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || lat != e.lat || num !== e.num || error !== e.err) begin
            failures++;
            $display("FAIL error_recover seen=%b lat=%0d num=%0d err=%b exp lat=%0d num=%0d err=%b",
                     seen, lat, num, error, e.lat, e.num, e.err);
        end
    endtask

    task automatic test_back_to_back();
        int          done_at [$];
        logic [13:0] got_num [$];
        exp_t        e;
        sb.push_back('{14'd5678, 1'b0, 16});
        sb.push_back('{14'd5678, 1'b0, 33});
        @(negedge clk);
        digits  = 32'h6D7D077F;
        convert = 1'b1;
        // k=0 is the first accepting edge; convert stays high through edge 33.
        for (int k = 0; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 33) convert = 1'b0;
            if (conv_done === 1'b1) begin
                done_at.push_back(k);
                got_num.push_back(num);
            end
        end
        checks++;
        if (done_at.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", done_at.size());
        end
        for (int j = 0; j < 2; j++) begin
            e = sb.pop_front();
            checks++;
            if (j >= done_at.size()) begin
                failures++;
                $display("FAIL b2b[%0d]_missing got=none exp=%0d@%0d", j, e.num, e.lat);
            end else if (done_at[j] != e.lat || got_num[j] !== e.num) begin
                failures++;
                $display("FAIL b2b[%0d] got=%0d@%0d exp=%0d@%0d", j, got_num[j], done_at[j],
                         e.num, e.lat);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int          done_at [$];
        logic [13:0] got_num [$];
        exp_t        e;
        sb.push_back('{14'd1234, 1'b0, 16});
        start_conv(32'h065B4F66);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (conv_done === 1'b1) begin
                done_at.push_back(i);
                got_num.push_back(num);
            end
            if (i == 5) begin
                digits  = 32'h6F6F6F6F;
                convert = 1'b1;
            end else begin
                convert = 1'b0;
            end
        end
        e = sb.pop_front();
        checks++;
        if (done_at.size() != 1) begin
            failures++;
            $display("FAIL ignore_count got=%0d exp=1", done_at.size());
        end else begin
            checks++;
            if (done_at[0] != e.lat || got_num[0] !== e.num) begin
                failures++;
                $display("FAIL ignore_result got=%0d@%0d exp=%0d@%0d", got_num[0], done_at[0],
                         e.num, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        bit   seen;
        int   spurious;
        start_conv(32'h6F6F6F6F);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (num !== 14'd0 || busy !== 1'b0 || conv_done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got num=%0d busy=%b done=%b err=%b exp 0/0/0/0",
                     num, busy, conv_done, error);
        end
        rst      = 1'b0;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (conv_done === 1'b1 || busy === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL rst_mid_aborted got=%0d active cycles exp=0", spurious);
        end
        sb.push_back('{14'd3012, 1'b0, 16});
        start_conv(32'h4F00065B);
        wait_done(lat, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || lat != e.lat || num !== e.num || error !== e.err) begin
            failures++;
            $display("FAIL rst_mid_next seen=%b lat=%0d num=%0d err=%b exp lat=%0d num=%0d err=%b",
                     seen, lat, num, error, e.lat, e.num, e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_error();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
